// File: rtl/pdm_demod.sv
// -----------------------------------------------------------------------------
// pdm_demod
//
// Decimates a 1-bit pulse-density-modulated stream to a PCM word by counting
// ones over a fixed window of 2^WINDOW_LOG2 sample ticks. A sample tick occurs
// once every CLK_DIV cycles of clk30. Each completed window is offered through
// a single-entry valid/ready output register.
//
// Parameters:
//   WINDOW_LOG2  window length is 2^WINDOW_LOG2 samples (2..16)
//   CLK_DIV      clk30 cycles per PDM sample (2..65535)
//
// Ports:
//   clk30      sole clock
//   rst        asynchronous active-high reset
//   pdm_in     asynchronous PDM bitstream (synchronised internally)
//   pcm_data   count of ones in the last window, 0..2^WINDOW_LOG2
//   pcm_valid  pcm_data holds an unconsumed result
//   pcm_ready  consumer accepts pcm_data when pcm_valid && pcm_ready
//   overrun    sticky flag: a completed window was dropped (cleared by rst)
//   pdm_clk    PDM clock for an external source (only with the macro below)
//
// Build option:
//   PDM_DEMOD_CLKOUT_EN  when defined, adds the registered pdm_clk output,
//                        low for the first CLK_DIV/2 counts of each sample
//                        period and high for the rest, so the source sees a
//                        rising edge mid-period and data is taken at period end.
// -----------------------------------------------------------------------------
module pdm_demod #(
  parameter int WINDOW_LOG2 = 8,
  parameter int CLK_DIV     = 10
) (
  input  logic                   clk30,
  input  logic                   rst,
  input  logic                   pdm_in,
  output logic [WINDOW_LOG2:0]   pcm_data,
  output logic                   pcm_valid,
  input  logic                   pcm_ready,
  output logic                   overrun
`ifdef PDM_DEMOD_CLKOUT_EN
  ,
  output logic                   pdm_clk
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]       DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [WINDOW_LOG2-1:0] IDX_LAST = '1;

  // Running count plus the current sample. The accumulator holds at most
  // 2^WINDOW_LOG2-1 before the last sample, so the extra bit never overflows.
  function automatic logic [WINDOW_LOG2:0] add_sample(
    input logic [WINDOW_LOG2:0] sum,
    input logic                 bit_in
  );
    return sum + {{WINDOW_LOG2{1'b0}}, bit_in};
  endfunction

  logic                   s1;
  logic                   s2;
  logic [DIV_W-1:0]       div_cnt;
  logic [DIV_W-1:0]       div_nxt;
  logic                   tick;
  logic [WINDOW_LOG2:0]   acc;
  logic [WINDOW_LOG2-1:0] idx;
  logic                   win_done;
  logic [WINDOW_LOG2:0]   result;
  logic                   load;

  assign tick     = (div_cnt == DIV_LAST);
  assign div_nxt  = tick ? '0 : div_cnt + DIV_W'(1);
  assign win_done = tick && (idx == IDX_LAST);
  assign result   = add_sample(acc, s2);
  // A finished window may enter the register when it is empty or being
  // drained on this very edge.
  assign load     = win_done && (!pcm_valid || pcm_ready);

  // ---- stage: input synchroniser ----
  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pdm_in;
      s2 <= s1;
    end
  end

  // ---- stage: sample divider and window accumulator ----
  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      acc     <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= div_nxt;
      if (tick) begin
        idx <= idx + WINDOW_LOG2'(1);
        acc <= win_done ? '0 : result;
      end
    end
  end

  // ---- stage: output register and overrun flag ----
  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        pcm_data  <= result;
        pcm_valid <= 1'b1;
      end else if (win_done) begin
        overrun   <= 1'b1;
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
    end
  end

`ifdef PDM_DEMOD_CLKOUT_EN
  // ---- stage: external PDM clock ----
  // Decoded from the next divider value so the flop tracks div_cnt exactly.
  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      pdm_clk <= 1'b0;
    end else begin
      pdm_clk <= (div_nxt >= DIV_HALF);
    end
  end
`endif

endmodule

// File: tb/tb_pdm_demod.sv
// -----------------------------------------------------------------------------
// tb_pdm_demod
//
// Bench for pdm_demod at default parameters. A behavioural model records the
// PDM input seen at every edge, forms each window's count from that history
// and tracks the valid/ready register; a compare process checks every output
// on each falling edge. Directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_pdm_demod;

  localparam int WL2 = 8;
  localparam int DIV = 10;
  localparam int WIN = 1 << WL2;
  localparam int WCY = WIN * DIV;   // edges per window

  logic           clk30 = 1'b0;
  logic           rst   = 1'b1;
  logic           pdm_in = 1'b0;
  logic           pcm_ready = 1'b1;
  logic [WL2:0]   pcm_data;
  logic           pcm_valid;
  logic           overrun;
`ifdef PDM_DEMOD_CLKOUT_EN
  logic           pdm_clk;
`endif

  pdm_demod #(.WINDOW_LOG2(WL2), .CLK_DIV(DIV)) dut (
    .clk30     (clk30),
    .rst       (rst),
    .pdm_in    (pdm_in),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun)
`ifdef PDM_DEMOD_CLKOUT_EN
    ,
    .pdm_clk   (pdm_clk)
`endif
  );

  always #5 clk30 = ~clk30;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k     : edges since reset release
  // hist  : pdm_in value present just before each edge
  // Sample n uses the input present before edge n*DIV-2 (two synchroniser
  // stages); every WIN samples the sum is offered to the output register.
  bit  hist [0:32767];
  int  k      = 0;
  int  wsum   = 0;
  bit  mvalid = 0;
  int  mdata  = 0;
  bit  movr   = 0;

  always @(posedge clk30 or posedge rst) begin : model
    int  nk;
    int  ws;
    bit  done;
    if (rst) begin
      k      <= 0;
      wsum   <= 0;
      mvalid <= 0;
      mdata  <= 0;
      movr   <= 0;
    end else begin
      nk   = k + 1;
      ws   = wsum;
      done = 0;
      hist[nk] <= pdm_in;
      if (nk % DIV == 0) begin
        ws = ws + int'(hist[nk - 2]);
        if ((nk / DIV) % WIN == 0) done = 1;
      end
      k    <= nk;
      wsum <= done ? 0 : ws;
      if (done) begin
        if (!mvalid || pcm_ready) begin
          mdata  <= ws;
          mvalid <= 1;
        end else begin
          movr   <= 1;
        end
      end else if (mvalid && pcm_ready) begin
        mvalid <= 0;
      end
    end
  end

  // ---------------- cycle compare ----------------
  always @(negedge clk30) begin
    chk("pcm_data",  int'(pcm_data),  mdata);
    chk("pcm_valid", int'(pcm_valid), int'(mvalid));
    chk("overrun",   int'(overrun),   int'(movr));
`ifdef PDM_DEMOD_CLKOUT_EN
    chk("pdm_clk",   int'(pdm_clk),   ((k % DIV) >= (DIV / 2)) ? 1 : 0);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk30);
  endtask

  task automatic do_reset();
    @(negedge clk30);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1; pdm_in = 1'b0; pcm_ready = 1'b1;
    run(3);
    chk("rst_data",  int'(pcm_data),  0);
    chk("rst_valid", int'(pcm_valid), 0);
    chk("rst_ovr",   int'(overrun),   0);
    rst = 1'b0;

    // All zeros: first result exactly after edge 2560, drained at 2561
    run(WCY - 1);
    chk("zero_pre_valid", int'(pcm_valid), 0);
    run(1);
    chk("zero_w1_valid", int'(pcm_valid), 1);
    chk("zero_w1_data",  int'(pcm_data),  0);
    run(1);
    chk("zero_drained",  int'(pcm_valid), 0);
    run(WCY - 1);
    chk("zero_w2_valid", int'(pcm_valid), 1);
    chk("zero_w2_data",  int'(pcm_data),  0);

    // All ones, input high before reset release
    pdm_in = 1'b1;
    do_reset();
    run(WCY);
    chk("ones_w1_data", int'(pcm_data), 256);
    run(WCY);
    chk("ones_w2_data", int'(pcm_data), 256);
    chk("ones_ovr",     int'(overrun),  0);

    // 50% pattern, toggling every 10 edges
    pdm_in = 1'b0;
    do_reset();
    for (int e = 1; e <= 3 * WCY; e++) begin
      @(negedge clk30);
      if (e == 2 * WCY) chk("half_w2_data", int'(pcm_data), 128);
      if (e == 3 * WCY) chk("half_w3_data", int'(pcm_data), 128);
      if (e % DIV == 0) pdm_in = ~pdm_in;
    end

    // Simultaneous handshake and completion: window 1 = 256, window 2 = 0
    pdm_in = 1'b1; pcm_ready = 1'b0;
    do_reset();
    run(WCY);
    chk("sim_w1_data", int'(pcm_data), 256);
    pdm_in = 1'b0;
    run(WCY - 1);
    chk("sim_pre_valid", int'(pcm_valid), 1);
    chk("sim_pre_data",  int'(pcm_data),  256);
    pcm_ready = 1'b1;
    run(1);
    pcm_ready = 1'b0;
    chk("sim_valid", int'(pcm_valid), 1);
    chk("sim_data",  int'(pcm_data),  0);
    chk("sim_ovr",   int'(overrun),   0);

    // Overrun: consumer stalled for three windows
    pdm_in = 1'b1; pcm_ready = 1'b0;
    do_reset();
    run(WCY);
    chk("ovr_w1_valid", int'(pcm_valid), 1);
    chk("ovr_w1_ovr",   int'(overrun),   0);
    run(WCY);
    chk("ovr_w2_ovr",   int'(overrun),   1);
    chk("ovr_w2_data",  int'(pcm_data),  256);
    run(WCY);
    chk("ovr_w3_data",  int'(pcm_data),  256);
    run(20);
    pcm_ready = 1'b1;
    run(1);
    pcm_ready = 1'b0;
    chk("ovr_drain_valid", int'(pcm_valid), 0);
    chk("ovr_sticky",      int'(overrun),   1);
    run(4 * WCY - 3 * WCY - 21 - 1);
    chk("ovr_w4_pre", int'(pcm_valid), 0);
    run(1);
    chk("ovr_w4_valid", int'(pcm_valid), 1);
    chk("ovr_w4_data",  int'(pcm_data),  256);
    chk("ovr_w4_ovr",   int'(overrun),   1);

    // Reset mid-window with a pending result and overrun set
    run(1300);
    #2 rst = 1'b1;
    #1;
    chk("amid_data",  int'(pcm_data),  0);
    chk("amid_valid", int'(pcm_valid), 0);
    chk("amid_ovr",   int'(overrun),   0);
    @(negedge clk30);
    rst = 1'b0;
    pcm_ready = 1'b1;
    run(WCY - 1);
    chk("amid_pre_valid", int'(pcm_valid), 0);
    run(1);
    chk("amid_valid2", int'(pcm_valid), 1);
    chk("amid_data2",  int'(pcm_data),  256);
    chk("amid_ovr2",   int'(overrun),   0);
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pdm_demod.md
# pdm_demod

Receive-side counterpart to the board's PDM outputs. Samples a 1-bit pulse-density-modulated stream on a PMOD/SYZYGY input pin and decimates it to a PCM word by counting ones over a fixed window of sample ticks. Results are delivered through a valid/ready register. Typical uses are loopback checking of the `pdm[2:0]` regulator drive and reading a PDM microphone.

## Interface
Parameters:
- `WINDOW_LOG2`, default 8: window length is 2^WINDOW_LOG2 samples; legal range 2..16.
- `CLK_DIV`, default 10: `clk30` cycles per PDM sample (3 MHz at 30 MHz); legal range 2..65535.

Ports:
- `clk30`  in  1  sole clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `pdm_in`  in  1  asynchronous PDM bitstream.
- `pcm_data`  out  WINDOW_LOG2+1  count of ones in the last window, 0..2^WINDOW_LOG2.
- `pcm_valid`  out  1  `pcm_data` holds an unconsumed result.
- `pcm_ready`  in  1  consumer accepts `pcm_data` when `pcm_valid && pcm_ready`.
- `overrun`  out  1  sticky: a completed window was dropped.
- `pdm_clk`  out  1  PDM clock for an external source; present only with `PDM_DEMOD_CLKOUT_EN`.

## Operation
- **Synchronizer.** `pdm_in` passes through 2 flops, `s1` then `s2`; both reset to 0.
- **Divider.** `div_cnt` counts 0..CLK_DIV-1 and wraps. `tick = (div_cnt == CLK_DIV-1)`.
- **Accumulate.** On each tick:
  - `acc` (WINDOW_LOG2+1 bits) adds `s2`.
  - `idx` (WINDOW_LOG2 bits) increments and wraps.
- **Window complete** when tick and `idx == 2^WINDOW_LOG2-1`:
  - The result is `acc + s2`.
  - `acc` is cleared to 0 in the same edge.
  - `acc` can never exceed 2^WINDOW_LOG2, so it never overflows.
- **Output register:**
  - The result loads into `pcm_data` and `pcm_valid` is set if the register is empty, or is being consumed in the same cycle.
  - Otherwise the result is discarded, `pcm_data` is unchanged, and `overrun` is set.
  - A handshake without a new load clears `pcm_valid`.
  - `pcm_data` is stable while `pcm_valid` is 1.
- **`overrun`** clears only on `rst`.
- **Reset values:** `div_cnt`=0, `acc`=0, `idx`=0, `pcm_data`=0, `pcm_valid`=0, `overrun`=0, `pdm_clk`=0.
- **Reset mid-window:** the partial window is lost and any pending result is lost. No output is generated for the partial window.

## Timing
- Edges are numbered 1, 2, … after `rst` deasserts.
- `div_cnt` = k mod CLK_DIV after edge k.
- Sample n (n ≥ 1) is accumulated at edge n·CLK_DIV and uses the `s2` value present before that edge.
- Input-to-sample latency is 2 edges (synchronizer) plus wait to the next tick.
- Window m (m ≥ 1) completes at edge m·2^WINDOW_LOG2·CLK_DIV. `pcm_valid` is high after that edge.
  - Default parameters: first result after edge 2560.
- **Simultaneous events:**
  - Handshake and completion in one cycle: new data loads, `pcm_valid` stays 1, no overrun.
  - Completion while `pcm_valid=1` and `pcm_ready=0`: `overrun` is 1 after that edge.
- Throughput is one result per 2^WINDOW_LOG2·CLK_DIV cycles. A consumer with `pcm_ready` tied high never overruns.

## Configuration
- Macro: `PDM_DEMOD_CLKOUT_EN`.
- **Defined:** port `pdm_clk` exists and is registered.
  - It is 0 while `div_cnt < CLK_DIV/2` (integer division) and 1 otherwise, taken from the registered `div_cnt` value.
  - The rising edge falls mid-period and samples are taken at period end.
  - Default parameters: 5 cycles low, 5 cycles high.
- **Undefined:** `pdm_clk` port and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use default parameters unless stated; `pcm_ready`=1 unless stated.
- **All zeros:** `pdm_in`=0 → `pcm_valid` rises after edge 2560 with `pcm_data`=0; next result after edge 5120, also 0.
- **All ones:** `pdm_in`=1 from before reset release → first `pcm_data`=256, then 256 every 2560 cycles.
- **50% pattern:** `pdm_in` toggles every 10 cycles, aligned to ticks → `pcm_data`=128 for each window after the first.
- **Overrun:** `pcm_ready`=0 for 3 windows with `pdm_in`=1 → `pcm_data` holds the first value, 256. `overrun`=1 after edge 5120. Raising `pcm_ready` yields one handshake, then `pcm_valid`=0 until the next window. `overrun` stays 1.
- **Simultaneous:** `pcm_ready` pulsed exactly in the completion cycle of window 2 → new value loaded, `pcm_valid` continuous, `overrun`=0.
- **Reset mid-window:** `rst` pulsed at edge 1300 → all outputs 0 immediately (asynchronous). The next `pcm_valid` occurs 2560 edges after release. With `PDM_DEMOD_CLKOUT_EN`, `pdm_clk` has period 10 and is high 5 cycles.
